montgomery_param: RTL

Parametrised bit-serial Montgomery multiplier, the width-generic successor to the fixed 1024-bit core. It computes A·B·2^-WIDTH mod M with one radix-2 iteration per clock, a final conditional subtraction, and a start/busy/done handshake. It also has a squaring mode. It sits between the operand register file and the modular-exponentiation controller.

---
 rtl/montgomery_param_pkg.sv | 27 ++
 rtl/montgomery_param_if.sv | 24 ++
 rtl/montgomery_param_addsub.sv | 23 ++
 rtl/montgomery_param.sv | 139 +++++++++++++
 4 files changed

// File: rtl/montgomery_param_pkg.sv
// Shared types and sizing helpers for the parametrised Montgomery multiplier.
package montgomery_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Plain-vector state codes matching the enum, for legacy-style state registers
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOOP = LOOP;
  localparam logic [1:0] ST_SUB  = SUB;
  localparam logic [1:0] ST_DONE = DONE;

  // Accumulator width: two guard bits keep C + B + M below 2^(WIDTH+2)
  function automatic int unsigned cw(input int unsigned width);
    return width + 2;
  endfunction

  // Iteration counter width
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/montgomery_param_if.sv
// Start/busy/done handshake and operand/result bus of the Montgomery multiplier.
interface montgomery_param_if #(
  parameter int unsigned WIDTH = 1024
) ();
  logic             start;
  logic             square;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, square, in_a, in_b, in_m,
    input  in_ready, busy, done, result
  );

  modport slave (
    input  start, square, in_a, in_b, in_m,
    output in_ready, busy, done, result
  );
endinterface

// File: rtl/montgomery_param_addsub.sv
// Combinational W-bit adder/subtractor; borrow is carry-out on add, borrow-out on subtract.
module mont_addsub #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         borrow
);

  logic [W:0]   full;
  logic [W-1:0] b_eff;

  // Two's-complement add of a and (optionally inverted) b
  always_comb begin
    b_eff  = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, b_eff} + (W+1)'(sub);
    sum    = full[W-1:0];
    borrow = sub ? ~full[W] : full[W];
  end

endmodule

// File: rtl/montgomery_param.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
module montgomery_param
  import montgomery_pkg::*;
#(
  parameter int unsigned WIDTH = 1024
) (
  input  logic               clk,
  input  logic               reset,
  montgomery_param_if.slave  bus
);

  localparam int unsigned CW    = cw(WIDTH);
  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;

  logic [CW-1:0]    badd_b, badd_sum;
  logic             badd_unused_carry;
  logic [CW-1:0]    madd_a, madd_b, madd_sum;
  logic             madd_sub, madd_borrow;
  logic [CW-1:0]    t_sel;
  logic             accept;

  // Adder operand steering: the M adder doubles as the final C - M subtractor
  always_comb begin
    badd_b   = a_q[0] ? {2'b00, b_q} : '0;
    madd_sub = (state_q == ST_SUB);
    madd_a   = madd_sub ? c_q : badd_sum;
    madd_b   = {2'b00, m_q};
    t_sel    = badd_sum[0] ? madd_sum : badd_sum;
  end

  mont_addsub #(.W(CW)) u_badd (
    .a      (c_q),
    .b      (badd_b),
    .sub    (1'b0),
    .sum    (badd_sum),
    .borrow (badd_unused_carry)
  );

  mont_addsub #(.W(CW)) u_madd (
    .a      (madd_a),
    .b      (madd_b),
    .sub    (madd_sub),
    .sum    (madd_sum),
    .borrow (madd_borrow)
  );

  // Next-state, datapath update and registered-output decode
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    result_d = result_q;
    accept   = bus.start && rdy_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOOP;
      end
      ST_LOOP: begin
        c_d     = t_sel >> 1;
        a_d     = a_q >> 1;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_LAST) begin
          count_d = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        result_d = madd_borrow ? c_q[WIDTH-1:0] : madd_sum[WIDTH-1:0];
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = accept ? ST_LOOP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Operand capture on acceptance (from IDLE or back-to-back from DONE)
    if (accept && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      count_d = '0;
      a_d     = bus.in_a;
      b_d     = bus.square ? bus.in_a : bus.in_b;
      m_d     = bus.in_m;
      c_d     = '0;
    end

    busy_d = (state_d == ST_LOOP) || (state_d == ST_SUB);
    rdy_d  = !busy_d;
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;

endmodule
